// File: rtl/batch_norm_chan_stream.sv
// batch_norm_chan_stream: per-channel INT8 batch norm y = sat(((x-mean)*scale+rnd)>>>FRAC_BITS + beta) on a valid/ready stream
// Ports:
//   clk, rst_n                        clock (rising edge), asynchronous active-low reset
//   cfg_we, cfg_ch                    write the parameter set of channel cfg_ch (cfg_ch >= NUM_CH ignored)
//   cfg_mean, cfg_scale, cfg_beta     signed mean, signed Q(FRAC_BITS) scale, signed output offset
//   ch_clr                            next accepted element goes to channel 0
//   sat_clr                           clear sat_cnt
//   in_valid, in_ready, in_data       input stream
//   out_valid, out_ready, out_data    output stream, signed saturated result
//   out_ch                            channel index of out_data
//   sat_cnt                           saturated output count, sticks at 16'hFFFF
// Build option: define BN_RELU_EN to clamp negative results to 0 (not counted as saturated).
module batch_norm_chan_stream #(
    parameter int DATA_WIDTH  = 8,
    parameter int PARAM_WIDTH = 8,
    parameter int FRAC_BITS   = 4,
    parameter int NUM_CH      = 4,
    localparam int CW         = $clog2(NUM_CH)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cfg_we,
    input  logic [CW-1:0]                 cfg_ch,
    input  logic signed [DATA_WIDTH-1:0]  cfg_mean,
    input  logic signed [PARAM_WIDTH-1:0] cfg_scale,
    input  logic signed [DATA_WIDTH-1:0]  cfg_beta,
    input  logic                          ch_clr,
    input  logic                          sat_clr,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [DATA_WIDTH-1:0]  in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [DATA_WIDTH-1:0]  out_data,
    output logic [CW-1:0]                 out_ch,
    output logic [15:0]                   sat_cnt
);
    localparam int DW  = DATA_WIDTH;
    localparam int PW  = PARAM_WIDTH;
    localparam int PWD = DW + PW + 1;
    // one extra bit over the product so adding beta can never wrap
    localparam logic signed [PWD:0] RND  = (PWD+1)'((1 << FRAC_BITS) >> 1);
    localparam logic signed [PWD:0] MAXV = (PWD+1)'(2**(DW-1) - 1);
    localparam logic signed [PWD:0] MINV = (PWD+1)'(-(2**(DW-1)));
`ifdef BN_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic signed [DW-1:0] mean_q  [NUM_CH];
    logic signed [PW-1:0] scale_q [NUM_CH];
    logic signed [DW-1:0] beta_q  [NUM_CH];
    logic [CW-1:0]        ptr;
    logic                 v1, v2;
    logic signed [DW:0]   d1;
    logic signed [PW-1:0] sc1;
    logic signed [DW-1:0] b1, b2;
    logic [CW-1:0]        c1, c2;
    logic signed [PWD-1:0] p2;
    logic signed [PWD:0]  r_sum;
    logic signed [DW-1:0] y;
    logic                 adv, accept, cfg_hit, hi, lo, neg, sat;

    assign adv      = !out_valid | out_ready;
    assign in_ready = adv;
    assign accept   = in_valid & adv;
    assign cfg_hit  = cfg_we & ({1'b0, cfg_ch} < (CW+1)'(NUM_CH));

    assign r_sum = (((PWD+1)'(p2) + RND) >>> FRAC_BITS) + (PWD+1)'(b2);
    assign hi    = r_sum > MAXV;
    assign lo    = r_sum < MINV;
    assign neg   = RELU && r_sum[PWD];
    assign sat   = hi | (lo & !RELU);
    assign y     = hi ? MAXV[DW-1:0] : neg ? '0 : lo ? MINV[DW-1:0] : r_sum[DW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                mean_q[i]  <= '0;
                scale_q[i] <= PW'(1 << FRAC_BITS);
                beta_q[i]  <= '0;
            end
        end else if (cfg_hit) begin
            mean_q[cfg_ch]  <= cfg_mean;
            scale_q[cfg_ch] <= cfg_scale;
            beta_q[cfg_ch]  <= cfg_beta;
        end
    end

    // ch_clr alone still redirects the next accepted element to channel 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= '0;
        else if (ch_clr)
            ptr <= '0;
        else if (accept)
            ptr <= (ptr == CW'(NUM_CH - 1)) ? '0 : ptr + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            d1        <= '0;
            sc1       <= '0;
            b1        <= '0;
            c1        <= '0;
            p2        <= '0;
            b2        <= '0;
            c2        <= '0;
            out_data  <= '0;
            out_ch    <= '0;
        end else if (adv) begin
            v1        <= accept;
            v2        <= v1;
            out_valid <= v2;
            if (accept) begin
                d1  <= (DW+1)'(in_data) - (DW+1)'(mean_q[ptr]);
                sc1 <= scale_q[ptr];
                b1  <= beta_q[ptr];
                c1  <= ptr;
            end
            if (v1) begin
                p2 <= PWD'(d1) * PWD'(sc1);
                b2 <= b1;
                c2 <= c1;
            end
            if (v2) begin
                out_data <= y;
                out_ch   <= c2;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sat_cnt <= '0;
        else if (sat_clr)
            sat_cnt <= '0;
        else if (adv && v2 && sat && !(&sat_cnt))
            sat_cnt <= sat_cnt + 16'd1;
    end
endmodule

// File: tb/tb_batch_norm_chan_stream.sv
// tb_batch_norm_chan_stream: directed self-checking bench for batch_norm_chan_stream
module tb_batch_norm_chan_stream;
    logic              clk = 1'b0;
    logic              rst_n;
    logic              cfg_we;
    logic [1:0]        cfg_ch;
    logic signed [7:0] cfg_mean;
    logic signed [7:0] cfg_scale;
    logic signed [7:0] cfg_beta;
    logic              ch_clr;
    logic              sat_clr;
    logic              in_valid;
    logic              in_ready;
    logic signed [7:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic signed [7:0] out_data;
    logic [1:0]        out_ch;
    logic [15:0]       sat_cnt;

    int checks = 0;
    int errors = 0;
    int sent   = 0;
    int lat;
    int exp_d[$];
    int exp_c[$];

    batch_norm_chan_stream dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_mean(cfg_mean), .cfg_scale(cfg_scale), .cfg_beta(cfg_beta),
        .ch_clr(ch_clr), .sat_clr(sat_clr), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ch(out_ch), .sat_cnt(sat_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic expect_out(input int d, input int c);
        exp_d.push_back(d);
        exp_c.push_back(c);
    endtask

    // inputs change on the falling edge; in_ready is sampled 2 time units later
    task automatic send(input int x);
        int t = 0;
        in_valid = 1'b1;
        in_data  = 8'(x);
        #2;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            #2;
            t++;
        end
        if (!in_ready) chk("send_timeout", t, 0);
        @(negedge clk);
        sent++;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic cfg(input int ch, input int m, input int s, input int b);
        cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_mean = 8'(m); cfg_scale = 8'(s); cfg_beta = 8'(b);
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic pulse_ch_clr();
        ch_clr = 1'b1;
        @(negedge clk);
        ch_clr = 1'b0;
    endtask

    task automatic drain();
        repeat (6) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_d.delete();
        exp_c.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // output monitor: checks every transfer against the expected queue
    always begin
        @(negedge clk);
        #1;
        if (rst_n && out_valid && out_ready) begin
            chk("out_expected", int'(exp_d.size() > 0), 1);
            if (exp_d.size() > 0) begin
                chk("out_data", out_data, exp_d.pop_front());
                chk("out_ch", out_ch, exp_c.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_mean = '0; cfg_scale = '0; cfg_beta = '0;
        ch_clr = 1'b0; sat_clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_ch", out_ch, 0);
        chk("rst_sat_cnt", sat_cnt, 0);
        chk("rst_in_ready", in_ready, 1);

        // unity pass-through, latency, channel rotation and wrap
        expect_out(100, 0);
        send(100);
        idle();
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, 3);
        expect_out(-7, 1); expect_out(0, 2); expect_out(5, 3); expect_out(9, 0);
        send(-7); send(0); send(5); send(9);
        idle();
        drain();

        // ptr now 1: (30-10)*32=640, +8 >>4 = 40, -5 = 35
        cfg(1, 10, 32, -5);
        expect_out(35, 1);
        send(30);
        idle();
        drain();

        // saturation high then low on ch0
        pulse_ch_clr();
        cfg(0, -128, 127, 0);
        expect_out(127, 0);
        send(127);
        idle();
        drain();
        chk("sat_cnt_hi", sat_cnt, 1);
        pulse_ch_clr();
        cfg(0, 127, 127, 0);
`ifdef BN_RELU_EN
        expect_out(0, 0);
`else
        expect_out(-128, 0);
`endif
        send(-128);
        idle();
        drain();
`ifdef BN_RELU_EN
        chk("sat_cnt_lo", sat_cnt, 1);
`else
        chk("sat_cnt_lo", sat_cnt, 2);
`endif
        sat_clr = 1'b1;
        @(negedge clk);
        sat_clr = 1'b0;
        chk("sat_clr", sat_cnt, 0);

        // backpressure: out_ready low for 5 cycles while input streams continuously
        do_reset();
        sent = 0;
        for (int i = 1; i <= 8; i++) expect_out(i, (i - 1) % 4);
        out_ready = 1'b0;
        fork
            begin
                for (int i = 1; i <= 8; i++) send(i);
                idle();
            end
            begin
                repeat (4) @(negedge clk);
                chk("stall_data_a", out_data, 1);
                @(negedge clk);
                chk("stall_in_ready", in_ready, 0);
                chk("stall_held", sent, 3);
                chk("stall_data_b", out_data, 1);
                chk("stall_ch", out_ch, 0);
                out_ready = 1'b1;
            end
        join
        drain();
        chk("stall_sent", sent, 8);

        // ch_clr with the 3rd accept, cfg write to ch2 in the same cycle
        do_reset();
        expect_out(11, 0); expect_out(12, 1); expect_out(60, 2);
        expect_out(13, 0); expect_out(14, 1); expect_out(10, 2);
        send(11);
        send(12);
        ch_clr = 1'b1;
        cfg_we = 1'b1; cfg_ch = 2'd2; cfg_mean = 8'sd50; cfg_scale = 8'sd16; cfg_beta = 8'sd0;
        send(60);
        ch_clr = 1'b0;
        cfg_we = 1'b0;
        send(13);
        send(14);
        send(60);
        idle();
        drain();

        // reset with 3 elements in flight drops them and restores unity params
        cfg(0, 10, 32, 0);
        out_ready = 1'b0;
        send(1); send(2); send(3);
        idle();
        chk("full_out_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", out_valid, 0);
        exp_d.delete();
        exp_c.delete();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_rst_quiet", out_valid, 0);
        end
        expect_out(20, 0);
        send(20);
        idle();
        drain();

`ifdef BN_RELU_EN
        // (30-10)*32 -> 40, -50 = -10 -> clamped to 0 by ReLU
        pulse_ch_clr();
        cfg(1, 10, 32, -50);
        expect_out(0, 0);
        expect_out(0, 1);
        send(0);
        send(30);
        idle();
        drain();
        chk("relu_sat_cnt", sat_cnt, 0);
`endif

        chk("queue_drained", exp_d.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
